// File: rtl/mac_operand_sequencer.sv
// Operand sequencer for a multiply-accumulate unit: clears the MAC, streams AccCycles operand pairs
// from two memories, waits for the MAC pipeline, then captures the sum. Optional abort: MAC_SEQ_ABORT_EN.
module mac_operand_sequencer #(
  parameter int bitwidthA      = 8,
  parameter int bitwidthB      = 8,
  parameter int AccCycles      = 400,  // 1 .. 2**addrWidth
  parameter int bitwidthAccRes = 25,
  parameter int addrWidth      = 9,
  parameter int MacLatency     = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
`ifdef MAC_SEQ_ABORT_EN
  input  logic                      abort,
`endif
  output logic                      busy,
  output logic                      done,
  output logic [addrWidth-1:0]      addrA,
  output logic [addrWidth-1:0]      addrB,
  input  logic [bitwidthA-1:0]      dataA,
  input  logic [bitwidthB-1:0]      dataB,
  output logic                      macClear,
  output logic                      newData,
  output logic [bitwidthA-1:0]      operandA,
  output logic [bitwidthB-1:0]      operandB,
  input  logic [bitwidthAccRes-1:0] AccResult,
  output logic [bitwidthAccRes-1:0] result,
  output logic                      resultValid,
  output logic [2:0]                dbg_state
);

  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN, CAPTURE} state_t;

  localparam int DrainW = (MacLatency > 0) ? $clog2(MacLatency + 1) : 1;
  localparam logic [addrWidth-1:0] LastAddr  = addrWidth'(AccCycles - 1);
  localparam logic [DrainW-1:0]    LastDrain = DrainW'(MacLatency);

  state_t                    state_q, state_d;
  logic [addrWidth-1:0]      addr_q, addr_d;
  logic [DrainW-1:0]         drain_q, drain_d;
  logic                      new_data_q, new_data_d;
  logic [bitwidthAccRes-1:0] result_q, result_d;
  logic                      result_valid_q, result_valid_d;
  logic                      abort_req;

`ifdef MAC_SEQ_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // Handshake: start is sampled only in IDLE; busy is high from CLEAR through CAPTURE; done pulses
  // for the single CAPTURE cycle. newData is a one-cycle-per-product strobe with no back-pressure.
  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    drain_d        = drain_q;
    new_data_d     = 1'b0;
    result_d       = result_q;
    result_valid_d = result_valid_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d        = CLEAR;
          result_valid_d = 1'b0;
        end
      end
      CLEAR: begin
        state_d = FETCH;
        addr_d  = '0;
      end
      FETCH: begin
        // Data for this address returns next cycle, which is when the product strobe fires.
        new_data_d = 1'b1;
        if (addr_q == LastAddr) begin
          state_d = DRAIN;
          addr_d  = '0;
          drain_d = '0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      DRAIN: begin
        if (drain_q == LastDrain) begin
          state_d        = CAPTURE;
          drain_d        = '0;
          result_d       = AccResult;
          result_valid_d = 1'b1;
        end else begin
          drain_d = drain_q + 1'b1;
        end
      end
      CAPTURE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_req && (state_q == CLEAR || state_q == FETCH || state_q == DRAIN)) begin
      state_d        = IDLE;
      addr_d         = '0;
      drain_d        = '0;
      new_data_d     = 1'b0;
      result_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      addr_q         <= '0;
      drain_q        <= '0;
      new_data_q     <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      drain_q        <= drain_d;
      new_data_q     <= new_data_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == CAPTURE);
  assign macClear    = (state_q == CLEAR);
  assign newData     = new_data_q;
  assign addrA       = addr_q;
  assign addrB       = addr_q;
  assign operandA    = new_data_q ? dataA : '0;
  assign operandB    = new_data_q ? dataB : '0;
  assign result      = result_q;
  assign resultValid = result_valid_q;
  assign dbg_state   = state_q;

endmodule
